// File: rtl/muldiv_e.sv
// Iterative 32-bit multiply/divide unit for the execute stage: shift-add multiply,
// restoring divide, sign fix-up, and HI/LO write-back in 33 cycles per operation.
module muldiv_e (
  input  logic        CLK,
  input  logic        RST,
  input  logic        StartE,
  input  logic [1:0]  MulDivOpE,
  input  logic [31:0] SrcAE,
  input  logic [31:0] SrcBE,
  input  logic        WrHiE,
  input  logic        WrLoE,
  output logic        BusyE,
  output logic        DoneE,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        is_div_q, is_div_d;
  logic        sa_q, sa_d;
  logic        sb_q, sb_d;
  logic        bzero_q, bzero_d;
  logic [31:0] opnd_q, opnd_d;
  logic [31:0] orig_a_q, orig_a_d;
  logic [63:0] acc_q, acc_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;

  logic        signed_op;
  logic [31:0] abs_a, abs_b;
  logic [32:0] rem_sh, diff, sum;
  logic [31:0] quot_sh;
  logic [63:0] prod;

  assign signed_op = ~MulDivOpE[0];
  assign abs_a     = (signed_op && SrcAE[31]) ? (32'd0 - SrcAE) : SrcAE;
  assign abs_b     = (signed_op && SrcBE[31]) ? (32'd0 - SrcBE) : SrcBE;

  always_comb begin
    // NOTE: every _d defaults to its _q first, so no path through the case leaves a latch.
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    bzero_d  = bzero_q;
    opnd_d   = opnd_q;
    orig_a_d = orig_a_q;
    acc_d    = acc_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    rem_sh   = acc_q[63:31];
    quot_sh  = {acc_q[30:0], 1'b0};
    diff     = rem_sh - {1'b0, opnd_q};
    sum      = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, opnd_q} : 33'd0);
    prod     = (sa_q ^ sb_q) ? (64'd0 - acc_q) : acc_q;

    case (state_q)
      S_IDLE: begin
        if (StartE) begin
          is_div_d = MulDivOpE[1];
          sa_d     = signed_op & SrcAE[31];
          sb_d     = signed_op & SrcBE[31];
          bzero_d  = (SrcBE == 32'd0);
          orig_a_d = SrcAE;
          cnt_d    = 5'd0;
          state_d  = S_RUN;
          // Divide keeps the divisor; multiply keeps the multiplicand and shifts the multiplier.
          if (MulDivOpE[1]) begin
            opnd_d = abs_b;
            acc_d  = {32'd0, abs_a};
          end else begin
            opnd_d = abs_a;
            acc_d  = {32'd0, abs_b};
          end
        end else begin
          if (WrHiE) hi_d = SrcAE;
          if (WrLoE) lo_d = SrcAE;
        end
      end
      S_RUN: begin
        if (is_div_q) begin
          if (rem_sh >= {1'b0, opnd_q}) acc_d = {diff[31:0], quot_sh[31:1], 1'b1};
          else                          acc_d = {rem_sh[31:0], quot_sh};
        end else begin
          acc_d = {sum, acc_q[31:1]};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        if (is_div_q) begin
          if (bzero_q) begin
            hi_d = orig_a_q;
            lo_d = 32'hFFFF_FFFF;
          end else begin
            lo_d = (sa_q ^ sb_q) ? (32'd0 - acc_q[31:0]) : acc_q[31:0];
            hi_d = sa_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
          end
        end else begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values in parallel.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= S_IDLE;
      cnt_q    <= 5'd0;
      is_div_q <= 1'b0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      bzero_q  <= 1'b0;
      opnd_q   <= 32'd0;
      orig_a_q <= 32'd0;
      acc_q    <= 64'd0;
      hi_q     <= 32'd0;
      lo_q     <= 32'd0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      bzero_q  <= bzero_d;
      opnd_q   <= opnd_d;
      orig_a_q <= orig_a_d;
      acc_q    <= acc_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
    end
  end

  assign BusyE = (state_q != S_IDLE);
  assign DoneE = done_q;
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule
